// File: rtl/reg_reader.sv
// reg_reader: operand-read stage with a {gf, num} pending-register scoreboard.
// Same-cycle write forwarding is compiled in when REG_READER_FWD_EN is defined.
module reg_reader #(
    parameter int WIDTH = 32,
    parameter int NUM   = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_gf_a,
    input  logic                 req_gf_b,
    input  logic [4:0]           req_num_a,
    input  logic [4:0]           req_num_b,
    input  logic                 req_dst_set,
    input  logic                 req_dst_gf,
    input  logic [4:0]           req_dst_num,
    input  logic [WIDTH*NUM-1:0] regs_g,
    input  logic [WIDTH*NUM-1:0] regs_f,
    input  logic                 w_gfflag,
    input  logic [4:0]           w_num,
    input  logic [WIDTH-1:0]     w_data,
    input  logic                 w_enable,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b
);

    // General register 0 is hard-wired zero, so its scoreboard bit is masked off.
    localparam logic [NUM-1:0] G_MASK = {{(NUM-1){1'b1}}, 1'b0};

    logic [NUM-1:0]   pend_g;
    logic [NUM-1:0]   pend_f;

    logic [NUM-1:0]   hot_a;
    logic [NUM-1:0]   hot_b;
    logic [NUM-1:0]   hot_d;
    logic [NUM-1:0]   hot_w;
    logic             zero_a;
    logic             zero_b;
    logic             pend_a;
    logic             pend_b;
    logic             fwd_a;
    logic             fwd_b;
    logic             haz_a;
    logic             haz_b;
    logic [WIDTH-1:0] file_a;
    logic [WIDTH-1:0] file_b;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;
    logic             accept;
    logic [NUM-1:0]   set_g;
    logic [NUM-1:0]   set_f;
    logic [NUM-1:0]   clr_g;
    logic [NUM-1:0]   clr_f;

    function automatic logic [NUM-1:0] decode(input logic [4:0] num);
        logic [NUM-1:0] hot;
        hot = '0;
        for (int i = 0; i < NUM; i++) begin
            if (num == 5'(i)) hot[i] = 1'b1;
        end
        return hot;
    endfunction

    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH*NUM-1:0] regs,
                                              input logic [4:0]           num);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM; i++) begin
            if (num == 5'(i)) v = regs[i*WIDTH +: WIDTH];
        end
        return v;
    endfunction

    always_comb begin
        hot_a  = decode(req_num_a);
        hot_b  = decode(req_num_b);
        zero_a = !req_gf_a && (req_num_a == 5'd0);
        zero_b = !req_gf_b && (req_num_b == 5'd0);
        pend_a = |(hot_a & (req_gf_a ? pend_f : (pend_g & G_MASK)));
        pend_b = |(hot_b & (req_gf_b ? pend_f : (pend_g & G_MASK)));
        file_a = req_gf_a ? pick(regs_f, req_num_a) : pick(regs_g, req_num_a);
        file_b = req_gf_b ? pick(regs_f, req_num_b) : pick(regs_g, req_num_b);
    end

`ifdef REG_READER_FWD_EN
    // A write landing this cycle both resolves the hazard and supplies the value,
    // since regs_g/regs_f still show the old contents until the edge.
    always_comb begin
        fwd_a = w_enable && (w_gfflag == req_gf_a) && (w_num == req_num_a) && !zero_a;
        fwd_b = w_enable && (w_gfflag == req_gf_b) && (w_num == req_num_b) && !zero_b;
    end
`else
    logic unused_w_data;

    always_comb begin
        fwd_a = 1'b0;
        fwd_b = 1'b0;
    end

    assign unused_w_data = ^w_data;
`endif

    always_comb begin
        haz_a = pend_a && !fwd_a;
        haz_b = pend_b && !fwd_b;

        if (zero_a)     val_a = '0;
        else if (fwd_a) val_a = w_data;
        else            val_a = file_a;

        if (zero_b)     val_b = '0;
        else if (fwd_b) val_b = w_data;
        else            val_b = file_b;
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; req_ready never depends on req_valid, and a producer holds its
    // payload stable while valid is high and ready is low.
    assign req_ready = (!out_valid || out_ready) && !haz_a && !haz_b;
    assign accept    = req_valid && req_ready;

    always_comb begin
        hot_d = (accept && req_dst_set) ? decode(req_dst_num) : '0;
        hot_w = w_enable ? decode(w_num) : '0;
        set_g = req_dst_gf ? '0 : (hot_d & G_MASK);
        set_f = req_dst_gf ? hot_d : '0;
        clr_g = w_gfflag ? '0 : hot_w;
        clr_f = w_gfflag ? hot_w : '0;
    end

    // Clear first, then set, so a same-cycle set of the same bit wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_g <= '0;
            pend_f <= '0;
        end else begin
            pend_g <= (pend_g & ~clr_g) | set_g;
            pend_f <= (pend_f & ~clr_f) | set_f;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= val_a;
            out_b     <= val_b;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/reg_reader.md
REG_READER -- requirements
Module: reg_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of one register.
REQ-002 SHALL have parameter NUM, default 32: register count per file; general and float files each hold NUM registers.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  operand-read request present.
REQ-006 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-007 req_gf_a, req_gf_b  input  1 each  source file select (0 general, 1 float).
REQ-008 req_num_a, req_num_b  input  5 each  source register numbers.
REQ-009 req_dst_set  input  1  request carries a destination to mark pending.
REQ-010 req_dst_gf  input  1; req_dst_num  input  5  destination register.
REQ-011 regs_g, regs_f  input  WIDTH*NUM each  flat register-file contents, register i at bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-012 w_gfflag  input  1; w_num  input  5; w_data  input  WIDTH; w_enable  input  1  register write port, same cycle as the file write.
REQ-013 out_valid  output  1; out_ready  input  1; out_a, out_b  output  WIDTH each  operand result handshake.

Function
REQ-014 SHALL keep a 2*NUM-bit pending scoreboard indexed {gf, num}.
REQ-015 Request acceptance: req_valid & req_ready at a rising edge.
REQ-016 req_ready SHALL be high only when (!out_valid | out_ready) and no source A or B is hazarded.
REQ-017 A source is hazarded when its scoreboard bit is set and it is not resolved by a same-cycle forward (REQ-025).
REQ-018 General register 0: always reads zero, never pending, never hazarded; req_dst_set on it marks nothing.
REQ-019 On acceptance, out_a/out_b SHALL load the selected values and out_valid SHALL go high the next cycle (1-cycle latency).
REQ-020 While out_valid & !out_ready, out_a, out_b, out_valid SHALL hold stable.
REQ-021 out_valid SHALL clear after an out_ready handshake with no new acceptance in the same cycle; handshake plus acceptance in the same cycle keeps out_valid high with the new data.
REQ-022 On acceptance with req_dst_set, the scoreboard bit {req_dst_gf, req_dst_num} SHALL be set.
REQ-023 w_enable SHALL clear the scoreboard bit {w_gfflag, w_num}; a write to a non-pending register leaves the scoreboard unchanged.
REQ-024 A set and a clear of the same bit in the same cycle: the set wins.
REQ-025 Forwarding (only with FWD_EN): w_enable with {w_gfflag, w_num} equal to a source resolves that hazard; the value comes from w_data instead of regs_g/regs_f.
REQ-026 With A == B, both SHALL receive the identical value.

Reset
REQ-027 rstn low SHALL immediately clear the scoreboard, out_valid, out_a and out_b to 0, regardless of clk.
REQ-028 Reset mid-stall or mid-hold SHALL discard the pending request and held output; req_ready SHALL be 1 after release.

Configuration
REQ-029 Macro REG_READER_FWD_EN defined: same-cycle write forwarding per REQ-025; a dependent request is accepted in the write cycle.
REQ-030 REG_READER_FWD_EN undefined: no forwarding path; a dependent request stalls until the cycle after the write and reads the value from regs_g/regs_f.

Verification
REQ-031 Reset, then request A=g3, B=f7 with regs_g[3]=0x11, regs_f[7]=0x22 -> next cycle out_valid=1, out_a=0x11, out_b=0x22.
REQ-032 Accept a request with dst g5, then request source g5; w_enable g5 = 0xABCD two cycles later -> stall; FWD_EN: accepted in the write cycle with out=0xABCD; without FWD_EN: accepted one cycle later.
REQ-033 Hold out_ready=0 for 3 cycles with a second request waiting -> req_ready=0 and out_a/out_b stable; out_ready=1 -> second result loaded in the same edge.
REQ-034 Request with dst g0, then source g0 -> no stall, out_a=0.
REQ-035 Same-cycle acceptance with dst f2 and w_enable f2 -> f2 stays pending; a following f2 read stalls until the next write to f2.
REQ-036 Assert rstn low while stalled on a pending register -> scoreboard cleared, out_valid=0, req_ready=1 after release.
